// File: rtl/ow_pkg.sv
// Shared types and microsecond timing constants for the 1-wire transaction controller.
package ow_pkg;

    typedef enum logic [1:0] {
        OW_OP_RESET = 2'd0,
        OW_OP_WRITE = 2'd1,
        OW_OP_READ  = 2'd2,
        OW_OP_RSVD  = 2'd3
    } ow_op_e;

    typedef enum logic [2:0] {
        OW_ST_IDLE     = 3'd0,
        OW_ST_RST_LOW  = 3'd1,
        OW_ST_RST_WAIT = 3'd2,
        OW_ST_SLOT_LOW = 3'd3,
        OW_ST_SLOT_REL = 3'd4,
        OW_ST_DONE     = 3'd5
    } ow_state_e;

    localparam int T_RST_US    = 480;
    localparam int T_PRES_US   = 70;
    localparam int T_LOW1_US   = 6;
    localparam int T_LOW0_US   = 60;
    localparam int T_RD_SMP_US = 15;
    localparam int T_SLOT_US   = 80;
    localparam int T_MAX_US    = 960;

endpackage

// File: rtl/ow_txn_ctrl_if.sv
// Command/response handshake bundle between a bus master and the 1-wire controller.
interface ow_txn_ctrl_if;
    import ow_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_presence, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_presence, busy
    );

endinterface

// File: rtl/ow_in_sync.sv
// Two-flop synchronizer for the raw 1-wire line, with an optional 3-sample
// majority filter enabled by OW_GLITCH_FILTER_EN.
module ow_in_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ow_i,
    output logic line_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ow_i};
        end
    end

`ifdef OW_GLITCH_FILTER_EN
    logic [2:0] win_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_q <= 3'b111;
        end else begin
            win_q <= {win_q[1:0], sync_q[1]};
        end
    end

    assign line_o = (win_q[0] & win_q[1]) |
                    (win_q[0] & win_q[2]) |
                    (win_q[1] & win_q[2]);
`else
    assign line_o = sync_q[1];
`endif

endmodule

// File: rtl/ow_txn_ctrl.sv
// 1-wire master: bus reset with presence detect, byte write and byte read,
// all timed by one down-counter. Optional input filter: OW_GLITCH_FILTER_EN.
module ow_txn_ctrl
    import ow_pkg::*;
#(
    parameter int CLK_PER_US = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_presence_o,
    output logic       busy_o,
    input  logic       ow_i,
    output logic       ow_o
);

    localparam logic [2:0] IDLE     = OW_ST_IDLE;
    localparam logic [2:0] RST_LOW  = OW_ST_RST_LOW;
    localparam logic [2:0] RST_WAIT = OW_ST_RST_WAIT;
    localparam logic [2:0] SLOT_LOW = OW_ST_SLOT_LOW;
    localparam logic [2:0] SLOT_REL = OW_ST_SLOT_REL;
    localparam logic [2:0] DONE     = OW_ST_DONE;

    localparam int CW = $clog2(T_MAX_US * CLK_PER_US + 1);

    // Reload values are "duration - 1" so each phase ends on cnt == 0.
    localparam logic [CW-1:0] N_RST  = CW'(T_RST_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] N_PRES = CW'((T_RST_US - T_PRES_US) * CLK_PER_US - 1);
    localparam logic [CW-1:0] N_LOW1 = CW'(T_LOW1_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] N_LOW0 = CW'(T_LOW0_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] N_REL1 = CW'((T_SLOT_US - T_LOW1_US) * CLK_PER_US - 1);
    localparam logic [CW-1:0] N_REL0 = CW'((T_SLOT_US - T_LOW0_US) * CLK_PER_US - 1);
    localparam logic [CW-1:0] N_RDS  = CW'((T_SLOT_US - T_RD_SMP_US) * CLK_PER_US - 1);

    function automatic logic [CW-1:0] slot_low(ow_op_e op, logic b);
        return (op == OW_OP_WRITE && !b) ? N_LOW0 : N_LOW1;
    endfunction

    function automatic logic [CW-1:0] slot_rel(ow_op_e op, logic b);
        return (op == OW_OP_WRITE && !b) ? N_REL0 : N_REL1;
    endfunction

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_q;
    logic [2:0]    bit_nxt;
    ow_op_e        op_q;
    logic [7:0]    data_q;
    logic [7:0]    shift_q;
    logic          pres_q;
    logic          ow_q;
    logic [7:0]    rsp_data_q;
    logic          rsp_pres_q;
    logic          line;

    ow_in_sync u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ow_i   (ow_i),
        .line_o (line)
    );

    assign bit_nxt = bit_q + 3'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_q      <= '0;
            op_q       <= OW_OP_RESET;
            data_q     <= '0;
            shift_q    <= '0;
            pres_q     <= 1'b0;
            ow_q       <= 1'b1;
            rsp_data_q <= '0;
            rsp_pres_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q   <= ow_op_e'(cmd_op_i);
                        data_q <= cmd_data_i;
                        bit_q  <= '0;
                        unique case (ow_op_e'(cmd_op_i))
                            OW_OP_RESET: begin
                                state <= RST_LOW;
                                cnt   <= N_RST;
                                ow_q  <= 1'b0;
                            end
                            OW_OP_WRITE, OW_OP_READ: begin
                                state <= SLOT_LOW;
                                cnt   <= slot_low(ow_op_e'(cmd_op_i), cmd_data_i[0]);
                                ow_q  <= 1'b0;
                            end
                            default: state <= DONE;
                        endcase
                    end
                end
                RST_LOW: begin
                    if (cnt == '0) begin
                        state <= RST_WAIT;
                        cnt   <= N_RST;
                        ow_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (cnt == N_PRES) begin
                        pres_q <= ~line;
                    end
                    if (cnt == '0) begin
                        state      <= DONE;
                        rsp_pres_q <= pres_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SLOT_LOW: begin
                    if (cnt == '0) begin
                        state <= SLOT_REL;
                        cnt   <= slot_rel(op_q, data_q[bit_q]);
                        ow_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SLOT_REL: begin
                    if (op_q == OW_OP_READ && cnt == N_RDS) begin
                        shift_q[bit_q] <= line;
                    end
                    if (cnt == '0) begin
                        if (bit_q == 3'd7) begin
                            state <= DONE;
                            if (op_q == OW_OP_READ) begin
                                rsp_data_q <= shift_q;
                            end
                        end else begin
                            bit_q <= bit_nxt;
                            state <= SLOT_LOW;
                            cnt   <= slot_low(op_q, data_q[bit_nxt]);
                            ow_q  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o    = (state == IDLE);
    assign busy_o         = (state != IDLE);
    assign rsp_valid_o    = (state == DONE);
    assign rsp_data_o     = rsp_data_q;
    assign rsp_presence_o = rsp_pres_q;
    assign ow_o           = ow_q;

endmodule

// File: tb/tb_ow_txn_ctrl.sv
// Bench for ow_txn_ctrl: 1-wire device model, time-based reference model,
// per-cycle output compare plus literal checks of the key timings.
module tb_ow_txn_ctrl;
    import ow_pkg::*;

    localparam int CPU  = 10;
    localparam int SLOT = 80 * CPU;
    localparam int LIM  = 12000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ow_i;
    logic ow_o;

    ow_txn_ctrl_if bus ();

    ow_txn_ctrl #(.CLK_PER_US(CPU)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_valid_i    (bus.cmd_valid),
        .cmd_ready_o    (bus.cmd_ready),
        .cmd_op_i       (bus.cmd_op),
        .cmd_data_i     (bus.cmd_data),
        .rsp_valid_o    (bus.rsp_valid),
        .rsp_data_o     (bus.rsp_data),
        .rsp_presence_o (bus.rsp_presence),
        .busy_o         (bus.busy),
        .ow_i           (ow_i),
        .ow_o           (ow_o)
    );

    // Open-drain device: answers resets with a presence pulse and
    // holds the line low through read slots whose bit is 0.
    bit       dev_pres_en = 0;
    bit       dev_rd_en   = 0;
    int       dev_pstart  = 300;
    int       dev_pwid    = 1500;
    bit [7:0] dev_byte    = 8'h00;
    bit       dev_pull    = 0;
    bit       rd_pull     = 0;
    int       low_run     = 0;
    int       rel_run     = 0;
    int       slot_run    = 0;
    int       last_low    = 0;
    int       rst_low_last = 0;
    int       slot_idx    = 0;
    int       widths[$];

    assign ow_i = ow_o & ~dev_pull;

    always @(negedge clk) begin
        if (ow_o === 1'b0) begin
            if (low_run == 0) begin
                slot_run = 0;
                rd_pull  = dev_rd_en && !dev_byte[slot_idx[2:0]];
                slot_idx = slot_idx + 1;
            end else begin
                slot_run++;
            end
            low_run++;
        end else begin
            if (low_run > 0) begin
                last_low = low_run;
                rel_run  = 0;
                if (low_run >= 4000) rst_low_last = low_run;
                else widths.push_back(low_run);
            end else begin
                rel_run++;
            end
            low_run = 0;
            slot_run++;
        end
        if (!dev_rd_en) begin
            slot_idx = 0;
            rd_pull  = 0;
        end
        dev_pull = (rd_pull && slot_run < 300) ||
                   (dev_pres_en && last_low >= 4000 &&
                    rel_run >= dev_pstart && rel_run < dev_pstart + dev_pwid);
    end

    // Reference: a command is just "elapsed cycles since acceptance".
    bit       m_act = 0;
    int       m_e   = 0;
    int       m_dur = 0;
    int       m_op  = 0;
    bit [7:0] m_data = 0;
    bit [7:0] m_rsp  = 0;
    bit       m_pres = 0;

    function automatic int dur_of(int op);
        case (op)
            0: return 2 * T_RST_US * CPU;
            1, 2: return 8 * SLOT;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act  = 0;
            m_rsp  = 0;
            m_pres = 0;
        end else if (m_act) begin
            m_e++;
            if (m_e == m_dur) begin
                if (m_op == 0) m_pres = dev_pres_en;
                if (m_op == 2) m_rsp = dev_rd_en ? dev_byte : 8'hFF;
            end
            if (m_e > m_dur) m_act = 0;
        end else if (bus.cmd_valid) begin
            m_act  = 1;
            m_e    = 0;
            m_op   = int'(bus.cmd_op);
            m_data = bus.cmd_data;
            m_dur  = dur_of(m_op);
        end
    end

    function automatic bit exp_ow();
        int off;
        int k;
        if (!m_act || m_e >= m_dur) return 1'b1;
        off = m_e % SLOT;
        k   = m_e / SLOT;
        case (m_op)
            0: return m_e >= T_RST_US * CPU;
            1: return off >= (m_data[k] ? 6 * CPU : 60 * CPU);
            2: return off >= 6 * CPU;
            default: return 1'b1;
        endcase
    endfunction

    int  tot    = 0;
    int  bad    = 0;
    int  nprint = 0;
    bit  chk_en = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            if (nprint < 40) begin
                $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
            end
            nprint++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            cmp("ready", 32'(bus.cmd_ready), 32'(!m_act));
            cmp("busy", 32'(bus.busy), 32'(m_act));
            cmp("rsp_valid", 32'(bus.rsp_valid), 32'(m_act && m_e == m_dur));
            cmp("ow_o", 32'(ow_o), 32'(exp_ow()));
            cmp("rsp_data", 32'(bus.rsp_data), 32'(m_rsp));
            cmp("presence", 32'(bus.rsp_presence), 32'(m_pres));
        end
    endtask

    task automatic wait_accept();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(m_act && m_e == 0) && n < 20);
        cmp("accept_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < LIM) begin
            tick();
            lat++;
        end
        cmp("rsp_timeout", 32'(lat < LIM), 32'd1);
    endtask

    task automatic run_cmd(input int op, input bit [7:0] d, output int lat);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op[1:0];
        bus.cmd_data  = d;
        wait_accept();
        bus.cmd_valid = 1'b0;
        wait_valid(lat);
        tick();
    endtask

    initial begin
        int lat;
        int n0;
        int nv;
        int guard;
        int op;
        bit [7:0] d;
        int exp_w[8] = '{60, 600, 60, 600, 600, 60, 600, 60};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 8'h00;
        tick();
        chk_en = 1;
        tick();
        tick();
        cmp("rst_ow", 32'(ow_o), 32'd1);
        cmp("rst_ready", 32'(bus.cmd_ready), 32'd1);
        cmp("rst_busy", 32'(bus.busy), 32'd0);
        cmp("rst_valid", 32'(bus.rsp_valid), 32'd0);
        cmp("rst_data", 32'(bus.rsp_data), 32'h00);
        cmp("rst_pres", 32'(bus.rsp_presence), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        dev_pres_en = 1;
        dev_pstart  = $urandom_range(150, 600);
        dev_pwid    = $urandom_range(1000, 3400);
        run_cmd(0, 8'h00, lat);
        cmp("reset_lat", lat, 9600);
        cmp("reset_low", rst_low_last, 4800);
        cmp("presence_on", 32'(bus.rsp_presence), 32'd1);

        dev_pres_en = 0;
        run_cmd(0, 8'h00, lat);
        cmp("presence_off", 32'(bus.rsp_presence), 32'd0);

        n0 = widths.size();
        run_cmd(1, 8'hA5, lat);
        cmp("write_lat", lat, 6400);
        cmp("write_slots", widths.size() - n0, 8);
        for (int k = 0; k < 8; k++) begin
            cmp($sformatf("write_w%0d", k), widths[n0 + k], exp_w[k]);
        end

        dev_rd_en = 1;
        dev_byte  = 8'h3C;
        run_cmd(2, 8'h00, lat);
        dev_rd_en = 0;
        cmp("read_lat", lat, 6400);
        cmp("read_data", 32'(bus.rsp_data), 32'h3C);

        run_cmd(3, 8'hFF, lat);
        cmp("rsvd_lat", lat, 0);
        cmp("rsvd_data", 32'(bus.rsp_data), 32'h3C);
        cmp("rsvd_pres", 32'(bus.rsp_presence), 32'd0);

        dev_rd_en = 1;
        dev_byte  = 8'h96;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_data  = 8'h00;
        wait_accept();
        wait_valid(lat);
        cmp("b2b_lat1", lat, 6400);
        tick();
        cmp("b2b_idle", 32'(bus.cmd_ready), 32'd1);
        tick();
        cmp("b2b_accept", 32'(bus.busy), 32'd1);
        bus.cmd_valid = 1'b0;
        wait_valid(lat);
        cmp("b2b_lat2", lat, 6400);
        cmp("b2b_data", 32'(bus.rsp_data), 32'h96);
        tick();
        dev_rd_en = 0;

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_data  = 8'h5A;
        wait_accept();
        bus.cmd_valid = 1'b0;
        guard = 0;
        while (m_act && m_e < 3 * SLOT + 30 && guard < LIM) begin
            tick();
            guard++;
        end
        cmp("midrst_low", 32'(ow_o), 32'd0);
        rst = 1'b1;
        tick();
        cmp("midrst_ow", 32'(ow_o), 32'd1);
        cmp("midrst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        nv = 0;
        repeat (900) begin
            tick();
            if (bus.rsp_valid === 1'b1) nv++;
        end
        cmp("midrst_novalid", nv, 0);

        for (int i = 0; i < 4; i++) begin
            op        = $urandom_range(1, 3);
            d         = 8'($urandom);
            dev_byte  = 8'($urandom);
            dev_rd_en = (op == 2);
            run_cmd(op, d, lat);
            cmp("rand_lat", lat, (op == 3) ? 0 : 6400);
            if (op == 2) cmp("rand_read", 32'(bus.rsp_data), 32'(dev_byte));
        end
        dev_rd_en = 0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
